// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the instruction sequencer and its register file.
// Contents:
//   DATA_W / NUM_REGS          : operand width and register file depth
//   OP_*                       : opcode encoding shared with the operacoes ALU
//   *_MSB / *_LSB / *_BIT      : instruction word field positions
//   seq_state_e                : sequencer FSM state encoding
//   opcode_legal()             : tells the sequencer which opcodes the ALU implements
package cpu_pkg;

  localparam int DATA_W   = 7;
  localparam int NUM_REGS = 4;

  // ALU opcode encoding
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD1 = 3'b010;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  // Instruction word layout; bit 7 is reserved and ignored
  localparam int OPC_MSB     = 15;
  localparam int OPC_LSB     = 13;
  localparam int RD_MSB      = 12;
  localparam int RD_LSB      = 11;
  localparam int RS_MSB      = 10;
  localparam int RS_LSB      = 9;
  localparam int IMM_SEL_BIT = 8;
  localparam int IMM_MSB     = 6;
  localparam int IMM_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WB    = 2'b10
  } seq_state_e;

  // An opcode is legal only if the ALU has a defined operation for it
  function automatic logic opcode_legal(input logic [2:0] opc);
    logic legal;
    case (opc)
      OP_LOAD: legal = 1'b1;
      OP_ADD1: legal = 1'b1;
      OP_SUBI: legal = 1'b1;
      OP_MUL:  legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/sequenciador_instr_banco_regs.sv
// banco_regs: NUM_REGS x DATA_W register file.
// Two asynchronous read ports, one synchronous write port, asynchronous clear.
// Ports:
//   clk, rst_n       : clock, async active-low clear of every entry
//   we, waddr, wdata : write port, takes effect on the rising edge
//   raddr1 / rdata1  : combinational read port 1
//   raddr2 / rdata2  : combinational read port 2
module banco_regs #(
  parameter int DATA_W   = 7,
  parameter int NUM_REGS = 4,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_r [NUM_REGS];

  // Storage: clear on reset, single write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata1 = mem_r[raddr1];
  assign rdata2 = mem_r[raddr2];

endmodule

// File: rtl/sequenciador_instr.sv
// sequenciador_instr: issues decoded instructions to the operacoes ALU and
// writes the ALU result back to the register file.
// One instruction takes three cycles: IDLE (accept) -> ISSUE -> WB -> IDLE.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   instr_valid, instr       : incoming instruction word (valid/ready)
//   instr_ready              : sequencer can accept an instruction
//   alu_opcode/op1/op2       : registered operands presented to the ALU
//   alu_q                    : registered ALU result, stable during WB
//   result, result_valid     : last written-back value, one-cycle pulse
//   illegal                  : one-cycle pulse on an undefined opcode
//   busy                     : high while an instruction is in ISSUE or WB
module sequenciador_instr #(
  parameter int DATA_W   = 7,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_q,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              illegal,
  output logic              busy
);

  import cpu_pkg::*;

  localparam int AW = $clog2(NUM_REGS);

  seq_state_e        state_r, state_s;
  logic              instr_ready_r, instr_ready_s;
  logic [2:0]        alu_opcode_r, alu_opcode_s;
  logic [DATA_W-1:0] alu_op1_r, alu_op1_s;
  logic [DATA_W-1:0] alu_op2_r, alu_op2_s;
  logic [DATA_W-1:0] result_r, result_s;
  logic              result_valid_r, result_valid_s;
  logic              illegal_r, illegal_s;
  logic              busy_r;
  logic [AW-1:0]     rd_r, rd_s;
  logic              we_s;

  // Decoded fields of the word currently on the instr bus
  logic [2:0]        f_opc_s;
  logic [AW-1:0]     f_rd_s;
  logic [AW-1:0]     f_rs_s;
  logic              f_sel_s;
  logic [DATA_W-1:0] f_imm_s;
  logic [DATA_W-1:0] rf_op1_s;
  logic [DATA_W-1:0] rf_op2_s;
  logic [DATA_W-1:0] op2_src_s;
  logic              accept_s;

  assign f_opc_s = instr[OPC_MSB:OPC_LSB];
  assign f_rd_s  = instr[RD_MSB:RD_LSB];
  assign f_rs_s  = instr[RS_MSB:RS_LSB];
  assign f_sel_s = instr[IMM_SEL_BIT];
  assign f_imm_s = instr[IMM_MSB:IMM_LSB];

  // Ready is only ever set while IDLE, but the state term keeps accept explicit
  assign accept_s = instr_valid & instr_ready_r & (state_r == ST_IDLE);

  // Operands are read at accept time; the previous writeback has already landed
  banco_regs #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_banco_regs (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we_s),
    .waddr  (rd_r),
    .wdata  (alu_q),
    .raddr1 (f_rd_s),
    .rdata1 (rf_op1_s),
    .raddr2 (f_rs_s),
    .rdata2 (rf_op2_s)
  );

  // Second operand source: immediate or register
  always_comb begin
    if (f_sel_s) begin
      op2_src_s = f_imm_s;
    end else begin
      op2_src_s = rf_op2_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s        = state_r;
    instr_ready_s  = instr_ready_r;
    alu_opcode_s   = alu_opcode_r;
    alu_op1_s      = alu_op1_r;
    alu_op2_s      = alu_op2_r;
    result_s       = result_r;
    result_valid_s = 1'b0;
    illegal_s      = 1'b0;
    rd_s           = rd_r;
    we_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!instr_ready_r) begin
          // first edge after reset release
          instr_ready_s = 1'b1;
        end else if (accept_s) begin
          if (opcode_legal(f_opc_s)) begin
            state_s       = ST_ISSUE;
            instr_ready_s = 1'b0;
            alu_opcode_s  = f_opc_s;
            alu_op1_s     = rf_op1_s;
            alu_op2_s     = op2_src_s;
            rd_s          = f_rd_s;
          end else begin
            // ALU inputs and registers untouched; ready stays high
            illegal_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // the ALU captures the held operands on this edge
        state_s = ST_WB;
      end
      ST_WB: begin
        state_s        = ST_IDLE;
        we_s           = 1'b1;
        result_s       = alu_q;
        result_valid_s = 1'b1;
        instr_ready_s  = 1'b1;
      end
      default: begin
        state_s       = ST_IDLE;
        instr_ready_s = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs and in-flight destination register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ready_r  <= 1'b0;
      alu_opcode_r   <= 3'b000;
      alu_op1_r      <= '0;
      alu_op2_r      <= '0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
      illegal_r      <= 1'b0;
      busy_r         <= 1'b0;
      rd_r           <= '0;
    end else begin
      instr_ready_r  <= instr_ready_s;
      alu_opcode_r   <= alu_opcode_s;
      alu_op1_r      <= alu_op1_s;
      alu_op2_r      <= alu_op2_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      illegal_r      <= illegal_s;
      busy_r         <= (state_s == ST_ISSUE) || (state_s == ST_WB);
      rd_r           <= rd_s;
    end
  end

  assign instr_ready  = instr_ready_r;
  assign alu_opcode   = alu_opcode_r;
  assign alu_op1      = alu_op1_r;
  assign alu_op2      = alu_op2_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign illegal      = illegal_r;
  assign busy         = busy_r;

endmodule
